uart_tx_param: RTL
==================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning tick pulses per bit period (legal 4..64).
REQ-003 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-004 Clock and reset SHALL be: one clock, bclk; reset rst, asynchronous and active-high.
REQ-005 Port: bclk, input, 1, sole clock, all state on rising edge.
REQ-006 Port: rst, input, 1, asynchronous active-high reset.
REQ-007 Port: tick, input, 1, one-cycle baud-oversample enable.
REQ-008 Port: tx_start, input, 1, request to send tx_data.
REQ-009 Port: tx_data, input, DATA_BITS, payload, sampled on acceptance.
REQ-010 Port: parity_odd, input, 1, 0 = even parity, 1 = odd; sampled on acceptance.
REQ-011 Port: tx, output, 1, serial line, idle high, registered.
REQ-012 Port: tx_ready, output, 1, high only in IDLE.
REQ-013 Port: tx_busy, output, 1, high in every state except IDLE.
REQ-014 Port: tx_done, output, 1, one-cycle pulse at frame end.

Function
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP, in that order per frame.
REQ-016 Acceptance SHALL occur at a rising edge with tx_start=1 and state IDLE; tx_data and parity_odd are latched into a shift register at that edge; tick is not required.
REQ-017 tx_start while busy SHALL be ignored, with no queuing and no effect on the frame in flight.
REQ-018 The edge after acceptance SHALL see state START and tx=0.
REQ-019 Each state SHALL hold for exactly OVERSAMPLE tick pulses counted from entry; the state advances at the edge where tick=1 and the tick counter equals OVERSAMPLE-1, and the counter clears on every state change.
REQ-020 DATA SHALL send DATA_BITS bits, LSB first; a bit counter (width clog2(DATA_BITS+1)) advances per bit period, and the last bit moves to PARITY (or STOP without parity, see REQ-028).
REQ-021 PARITY SHALL drive XOR of the latched payload XOR parity_odd.
REQ-022 STOP SHALL drive tx=1 for STOP_BITS*OVERSAMPLE ticks, then return to IDLE.
REQ-023 tx_done SHALL be 1 for exactly the first cycle in IDLE after STOP; tx_ready is also 1 in that cycle, so a back-to-back start is accepted there at earliest.
REQ-024 tick asserted on the acceptance edge SHALL NOT count toward the START period.
REQ-025 tick held permanently high SHALL be legal, giving a bit period of OVERSAMPLE clocks.
REQ-026 Changes on tx_data or parity_odd after acceptance SHALL NOT alter the frame.

Reset
REQ-027 rst=1 SHALL immediately force these values, including mid-frame with the frame discarded:
- state IDLE
- tx=1, tx_ready=1, tx_busy=0, tx_done=0
- tick and bit counters 0
- shift register 0

Configuration
REQ-028 Macro UART_TX_PARITY_EN SHALL control parity:
- Defined: PARITY state and parity_odd are present.
- Undefined: the PARITY state is removed, DATA goes directly to STOP, and parity_odd is present but ignored.

Verification (DATA_BITS=8, OVERSAMPLE=16, STOP_BITS=1, tick=1 every cycle, UART_TX_PARITY_EN defined)
REQ-029 Stimulus: send 0xA5 with parity_odd=0. Response:
- tx low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each.
- parity 0, then stop 1 for 16 cycles.
- tx_done pulse 177 cycles after acceptance.
REQ-030 Stimulus: send 0x07 with parity_odd=1. Response: parity bit = 0.
REQ-031 Stimulus: second tx_start at cycle 50 of a frame. Response: ignored, one frame only.
REQ-032 Stimulus: rst pulse at cycle 60 of a frame. Response: tx=1, tx_ready=1 immediately, no tx_done.
REQ-033 Stimulus: tick every 4th cycle. Response: bit period 64 cycles.
REQ-034 Stimulus: macro undefined, send 0xFF. Response: no parity bit, frame 160 cycles, tx_done at 161.

Source files
------------

// File: rtl/uart_tx_param_if.sv
// Handshake and serial-line bundle for uart_tx_param.
// The master drives requests and payload; the slave (the transmitter) drives the line and status.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick;
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 parity_odd;
    logic                 tx;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tick, tx_start, tx_data, parity_odd,
        input  tx, tx_ready, tx_busy, tx_done
    );

    modport slave (
        input  tick, tx_start, tx_data, parity_odd,
        output tx, tx_ready, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, DATA_BITS payload LSB first, optional parity, STOP_BITS stop bits.
// Parity is built in only when the macro UART_TX_PARITY_EN is defined.
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic           bclk,
    input  logic           rst,
    uart_tx_param_if.slave bus
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 period_end;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = bus.parity_odd;
`endif

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign period_end = bus.tick && (tick_cnt_q == LAST_TICK);

    // The tick counter only runs outside IDLE, so a tick on the acceptance edge is never counted.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        tx_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        if (state_q != IDLE && bus.tick) begin
            tick_cnt_d = period_end ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    state_d    = START;
                    shift_d    = bus.tx_data;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
                    par_d      = (^bus.tx_data) ^ bus.parity_odd;
`endif
                end
            end
            START: begin
                if (period_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (period_end) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (period_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
`endif
            STOP: begin
                if (period_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line is registered, so it is computed from the state being entered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = (state_q == IDLE);
    assign bus.tx_busy  = (state_q != IDLE);
    assign bus.tx_done  = done_q;
endmodule
